axi_apb_bridge_mslv: RTL and testbench
======================================

Name: axi_apb_bridge_mslv

Overview:
Parametrised AXI4-Lite slave to APB4 master bridge for up to 16 APB slaves on equal-size address windows. Serialises AXI reads and writes into one APB transfer at a time, with fair read/write arbitration, per-slave address decode, DECERR for unmapped addresses, and a PREADY timeout. It sits between the AXI4-Lite interconnect and the peripheral APB segment.

Parameters:
C_APB_NUM_SLAVES, 4, number of APB slaves (1..16); width of psel/pready/pslverr
C_ADDR_WIDTH, 32, AXI and APB address width
C_DATA_WIDTH, 32, data width (32 only); strobe width = C_DATA_WIDTH/8
BASE_ADDRESS, 32'h0000_0000, start of slave 0 window
SLAVE_SIZE, 256, bytes per slave window (power of 2)
C_TIMEOUT, 16, ACCESS cycles without pready before abort; 0 disables

Ports:
s_axi_clk  in  1  clock
s_axi_areset  in  1  reset; one clock; reset is synchronous and active-high
s_axi_awaddr/s_axi_araddr  in  C_ADDR_WIDTH  write/read address
s_axi_awprot/s_axi_arprot  in  3  protection
s_axi_awvalid/s_axi_arvalid  in  1  address valid
s_axi_awready/s_axi_arready  out  1  address ready
s_axi_wdata  in  C_DATA_WIDTH  write data
s_axi_wstrb  in  C_DATA_WIDTH/8  byte strobes
s_axi_wvalid  in 1 ; s_axi_wready  out  1  write data handshake
s_axi_bresp  out  2 ; s_axi_bvalid  out  1 ; s_axi_bready  in  1  write response
s_axi_rdata  out  C_DATA_WIDTH ; s_axi_rresp  out  2 ; s_axi_rvalid  out  1 ; s_axi_rready  in  1  read response
m_apb_paddr  out  C_ADDR_WIDTH ; m_apb_pprot  out  3 ; m_apb_pwrite  out  1 ; m_apb_penable  out  1
m_apb_psel  out  C_APB_NUM_SLAVES  one-hot select
m_apb_pwdata  out  C_DATA_WIDTH ; m_apb_pstrb  out  C_DATA_WIDTH/8
m_apb_pready  in  C_APB_NUM_SLAVES ; m_apb_pslverr  in  C_APB_NUM_SLAVES  per-slave
m_apb_prdata  in  C_APB_NUM_SLAVES*C_DATA_WIDTH  flattened; slave k at bits [k*DW +: DW]

Behaviour:
- FSM IDLE, SETUP, ACCESS, RESP. All outputs registered except ready signals (combinational from state and valids).
- Reset: state IDLE, all readies/valids/psel/penable/pwrite 0, paddr/pwdata/pstrb/pprot/rdata/resp 0, priority = read. Reset mid-transfer drops it; no AXI response issued.
- IDLE: read candidate = arvalid; write candidate = awvalid AND wvalid (AW alone never accepted). If both, grant priority holder; priority flips to the other type after each granted transfer. Grant asserts arready, or awready+wready together, that cycle; addr, prot, wdata, wstrb captured.
- Decode: idx = (addr-BASE_ADDRESS)/SLAVE_SIZE. addr < BASE_ADDRESS or idx >= C_APB_NUM_SLAVES -> no APB transfer, go RESP with resp 2'b11 (DECERR), rdata 0.
- SETUP (1 cycle): psel[idx]=1, penable=0, paddr=captured addr, pwrite=1 for write; pwdata/pstrb = captured for write, 0 for read.
- ACCESS: penable=1; hold all APB outputs until pready[idx]. On pready: capture prdata slice idx (reads), resp = pslverr[idx] ? 2'b10 : 2'b00; psel/penable -> 0; go RESP.
- Timeout: counter cleared in SETUP, increments each ACCESS cycle without pready; at C_TIMEOUT, abort: psel/penable -> 0, resp 2'b10, rdata 0, go RESP. pready in the same cycle as terminal count wins.
- RESP: bvalid (write) or rvalid (read) held with stable payload until bready/rready; then IDLE. No new AXI acceptance until IDLE.
- Latency, zero-wait slave: handshake T0, SETUP T1, ACCESS T2, valid T3.
- Only one pready/pslverr bit (idx) is sampled; others ignored.

Test Plan:
- Read slave 2 (addr BASE+0x204), pready=1 immediately, prdata slice2=0xCAFE_F00D -> psel=4'b0100 T1, penable T2, rvalid T3 rdata 0xCAFE_F00D rresp 00.
- Write 0x1234_5678 wstrb 4'b0011 to slave 1, pready after 3 wait cycles, pslverr=1 -> pstrb 0011, pwrite 1, bvalid with bresp 10 after final ACCESS cycle.
- arvalid, awvalid, wvalid all high after reset -> read granted first, write next; then with both pending again, write granted before read.
- awvalid=1, wvalid=0 for 10 cycles -> awready stays 0, no psel; wvalid rises -> awready=wready=1 same cycle.
- Read addr BASE+4*SLAVE_SIZE with 4 slaves -> no psel, rvalid 2 cycles later, rresp 11, rdata 0.
- pready held 0, C_TIMEOUT=16 -> abort after 16 ACCESS cycles, rresp 10; rready held 0 for 5 cycles -> rvalid/rdata stable; reset in ACCESS -> psel 0 next cycle, no rvalid.

Source files
------------

// File: rtl/axi_apb_bridge_mslv_if.sv
// axi_apb_bridge_mslv_if: AXI4-Lite slave side and APB4 master side bundled for the bridge
// slave modport: the bridge view (AXI inputs/readies+responses out, APB requests out/replies in)
// master modport: the surrounding view (AXI master plus APB slaves)
interface axi_apb_bridge_mslv_if #(
    parameter int C_APB_NUM_SLAVES = 4,
    parameter int C_ADDR_WIDTH     = 32,
    parameter int C_DATA_WIDTH     = 32
) ();
    logic [C_ADDR_WIDTH-1:0]                  s_axi_awaddr, s_axi_araddr;
    logic [2:0]                               s_axi_awprot, s_axi_arprot;
    logic                                     s_axi_awvalid, s_axi_awready;
    logic                                     s_axi_arvalid, s_axi_arready;
    logic [C_DATA_WIDTH-1:0]                  s_axi_wdata;
    logic [C_DATA_WIDTH/8-1:0]                s_axi_wstrb;
    logic                                     s_axi_wvalid, s_axi_wready;
    logic [1:0]                               s_axi_bresp;
    logic                                     s_axi_bvalid, s_axi_bready;
    logic [C_DATA_WIDTH-1:0]                  s_axi_rdata;
    logic [1:0]                               s_axi_rresp;
    logic                                     s_axi_rvalid, s_axi_rready;
    logic [C_ADDR_WIDTH-1:0]                  m_apb_paddr;
    logic [2:0]                               m_apb_pprot;
    logic                                     m_apb_pwrite, m_apb_penable;
    logic [C_APB_NUM_SLAVES-1:0]              m_apb_psel;
    logic [C_DATA_WIDTH-1:0]                  m_apb_pwdata;
    logic [C_DATA_WIDTH/8-1:0]                m_apb_pstrb;
    logic [C_APB_NUM_SLAVES-1:0]              m_apb_pready, m_apb_pslverr;
    logic [C_APB_NUM_SLAVES*C_DATA_WIDTH-1:0] m_apb_prdata;

    modport slave (
        input  s_axi_awaddr, s_axi_awprot, s_axi_awvalid, s_axi_araddr, s_axi_arprot, s_axi_arvalid,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wvalid, s_axi_bready, s_axi_rready,
        input  m_apb_pready, m_apb_pslverr, m_apb_prdata,
        output s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        output s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        output m_apb_paddr, m_apb_pprot, m_apb_pwrite, m_apb_penable, m_apb_psel, m_apb_pwdata, m_apb_pstrb
    );

    modport master (
        output s_axi_awaddr, s_axi_awprot, s_axi_awvalid, s_axi_araddr, s_axi_arprot, s_axi_arvalid,
        output s_axi_wdata, s_axi_wstrb, s_axi_wvalid, s_axi_bready, s_axi_rready,
        output m_apb_pready, m_apb_pslverr, m_apb_prdata,
        input  s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        input  s_axi_rdata, s_axi_rresp, s_axi_rvalid,
        input  m_apb_paddr, m_apb_pprot, m_apb_pwrite, m_apb_penable, m_apb_psel, m_apb_pwdata, m_apb_pstrb
    );
endinterface

// File: rtl/axi_apb_bridge_mslv.sv
// axi_apb_bridge_mslv: AXI4-Lite slave to APB4 master bridge, one APB transfer at a time
// s_axi_clk: clock; s_axi_areset: synchronous active-high reset
// bus: axi_apb_bridge_mslv_if.slave carrying the AXI4-Lite slave and APB4 master signals
module axi_apb_bridge_mslv #(
    parameter int                      C_APB_NUM_SLAVES = 4,
    parameter int                      C_ADDR_WIDTH     = 32,
    parameter int                      C_DATA_WIDTH     = 32,
    parameter logic [C_ADDR_WIDTH-1:0] BASE_ADDRESS     = '0,
    parameter int                      SLAVE_SIZE       = 256,
    parameter int                      C_TIMEOUT        = 16
) (
    input logic                   s_axi_clk,
    input logic                   s_axi_areset,
    axi_apb_bridge_mslv_if.slave  bus
);
    localparam int NS = C_APB_NUM_SLAVES;
    localparam int AW = C_ADDR_WIDTH;
    localparam int DW = C_DATA_WIDTH;
    localparam int SW = $clog2(SLAVE_SIZE);
    localparam int IW = NS > 1 ? $clog2(NS) : 1;
    localparam int TW = $clog2(C_TIMEOUT + 2);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t          state_q;
    logic            prio_rd_q, is_wr_q, hit_q;
    logic [IW-1:0]   idx_q;
    logic [TW-1:0]   cnt_q;
    logic [AW-1:0]   paddr_q;
    logic [2:0]      pprot_q;
    logic            pwrite_q, penable_q, rvalid_q, bvalid_q;
    logic [NS-1:0]   psel_q;
    logic [DW-1:0]   pwdata_q, rdata_q;
    logic [DW/8-1:0] pstrb_q;
    logic [1:0]      resp_q;

    logic            wr_req, rd_gnt, wr_gnt, hit;
    logic [AW-1:0]   addr, off, slot;
    logic [IW-1:0]   idx;
    logic [DW-1:0]   prd [NS];

    for (genvar k = 0; k < NS; k++) begin : g_prd
        assign prd[k] = bus.m_apb_prdata[k*DW +: DW];
    end

    // A write needs address and data together; the priority holder wins a tie.
    assign wr_req = bus.s_axi_awvalid & bus.s_axi_wvalid;
    assign rd_gnt = state_q == IDLE && bus.s_axi_arvalid && (prio_rd_q || !wr_req);
    assign wr_gnt = state_q == IDLE && wr_req && (!prio_rd_q || !bus.s_axi_arvalid);
    assign addr   = rd_gnt ? bus.s_axi_araddr : bus.s_axi_awaddr;
    assign off    = addr - BASE_ADDRESS;
    assign slot   = off >> SW;
    assign hit    = addr >= BASE_ADDRESS && slot < AW'(NS);
    assign idx    = slot[IW-1:0];

    assign bus.s_axi_arready = rd_gnt;
    assign bus.s_axi_awready = wr_gnt;
    assign bus.s_axi_wready  = wr_gnt;
    assign bus.s_axi_bresp   = resp_q;
    assign bus.s_axi_bvalid  = bvalid_q;
    assign bus.s_axi_rresp   = resp_q;
    assign bus.s_axi_rdata   = rdata_q;
    assign bus.s_axi_rvalid  = rvalid_q;
    assign bus.m_apb_paddr   = paddr_q;
    assign bus.m_apb_pprot   = pprot_q;
    assign bus.m_apb_pwrite  = pwrite_q;
    assign bus.m_apb_penable = penable_q;
    assign bus.m_apb_psel    = psel_q;
    assign bus.m_apb_pwdata  = pwdata_q;
    assign bus.m_apb_pstrb   = pstrb_q;

    always_ff @(posedge s_axi_clk) begin
        if (s_axi_areset) begin
            state_q   <= IDLE;
            prio_rd_q <= 1'b1;
            is_wr_q   <= 1'b0;
            hit_q     <= 1'b0;
            idx_q     <= '0;
            cnt_q     <= '0;
            paddr_q   <= '0;
            pprot_q   <= '0;
            pwrite_q  <= 1'b0;
            penable_q <= 1'b0;
            psel_q    <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= '0;
            rvalid_q  <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (rd_gnt || wr_gnt) begin
                    state_q   <= SETUP;
                    prio_rd_q <= wr_gnt;
                    is_wr_q   <= wr_gnt;
                    hit_q     <= hit;
                    idx_q     <= idx;
                    paddr_q   <= addr;
                    pprot_q   <= wr_gnt ? bus.s_axi_awprot : bus.s_axi_arprot;
                    pwrite_q  <= wr_gnt && hit;
                    psel_q    <= hit ? NS'(1) << idx : '0;
                    pwdata_q  <= wr_gnt ? bus.s_axi_wdata : '0;
                    pstrb_q   <= wr_gnt ? bus.s_axi_wstrb : '0;
                end
                // Unmapped addresses spend this cycle without select, then answer DECERR.
                SETUP: if (hit_q) begin
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= ACCESS;
                end else begin
                    resp_q   <= 2'b11;
                    rdata_q  <= '0;
                    rvalid_q <= !is_wr_q;
                    bvalid_q <= is_wr_q;
                    state_q  <= RESP;
                end
                ACCESS: if (bus.m_apb_pready[idx_q]) begin
                    if (!is_wr_q) rdata_q <= prd[idx_q];
                    resp_q    <= bus.m_apb_pslverr[idx_q] ? 2'b10 : 2'b00;
                    psel_q    <= '0;
                    penable_q <= 1'b0;
                    rvalid_q  <= !is_wr_q;
                    bvalid_q  <= is_wr_q;
                    state_q   <= RESP;
                end else if (C_TIMEOUT != 0 && cnt_q == TW'(C_TIMEOUT - 1)) begin
                    rdata_q   <= '0;
                    resp_q    <= 2'b10;
                    psel_q    <= '0;
                    penable_q <= 1'b0;
                    rvalid_q  <= !is_wr_q;
                    bvalid_q  <= is_wr_q;
                    state_q   <= RESP;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                RESP: if (is_wr_q ? bus.s_axi_bready : bus.s_axi_rready) begin
                    rvalid_q <= 1'b0;
                    bvalid_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_apb_bridge_mslv.sv
// tb_axi_apb_bridge_mslv: scoreboard bench for the AXI4-Lite to APB4 bridge
module tb_axi_apb_bridge_mslv;
    typedef struct {logic wr; logic [1:0] resp; logic [31:0] data;} exp_t;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    int    checks = 0;
    int    errors = 0;
    int    wait_cfg = 0;
    bit    err_cfg = 1'b0;
    exp_t  sb[$];
    string gnt_log = "";

    axi_apb_bridge_mslv_if bus ();

    axi_apb_bridge_mslv dut (
        .s_axi_clk(clk),
        .s_axi_areset(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // APB slave model: answers the selected slave after wait_cfg wait cycles.
    initial begin
        int acc;
        acc = 0;
        bus.m_apb_pready  = '0;
        bus.m_apb_pslverr = '0;
        bus.m_apb_prdata  = {32'h1000_0003, 32'hCAFE_F00D, 32'h1000_0001, 32'h1000_0000};
        forever begin
            @(negedge clk);
            if (|bus.m_apb_psel && bus.m_apb_penable) begin
                bus.m_apb_pready  = (acc == wait_cfg) ? bus.m_apb_psel : '0;
                bus.m_apb_pslverr = err_cfg ? bus.m_apb_psel : '0;
                acc++;
            end else begin
                bus.m_apb_pready  = '0;
                bus.m_apb_pslverr = '0;
                acc = 0;
            end
        end
    end

    // Response monitor: every AXI response handshake pops one scoreboard entry.
    initial begin
        exp_t e;
        logic w;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && ((bus.s_axi_rvalid && bus.s_axi_rready) || (bus.s_axi_bvalid && bus.s_axi_bready))) begin
                w = bus.s_axi_bvalid && bus.s_axi_bready;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected wr=%0b resp=%b rdata=%h", w, w ? bus.s_axi_bresp : bus.s_axi_rresp, bus.s_axi_rdata);
                end else begin
                    e = sb.pop_front();
                    if (w !== e.wr || (w ? bus.s_axi_bresp : bus.s_axi_rresp) !== e.resp || (!w && bus.s_axi_rdata !== e.data)) begin
                        errors++;
                        $display("FAIL sb_resp got wr=%0b resp=%b data=%h exp wr=%0b resp=%b data=%h",
                                 w, w ? bus.s_axi_bresp : bus.s_axi_rresp, bus.s_axi_rdata, e.wr, e.resp, e.data);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Raises a read request, waits for arready, returns at the following negedge with arvalid low.
    task automatic send_rd(input logic [31:0] a, input bit push, input logic [1:0] r, input logic [31:0] d);
        int n;
        n = 0;
        @(negedge clk);
        bus.s_axi_araddr  = a;
        bus.s_axi_arprot  = 3'b001;
        bus.s_axi_arvalid = 1'b1;
        #1;
        while (!bus.s_axi_arready && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (bus.s_axi_arready !== 1'b1) begin
            errors++;
            $display("FAIL ar_grant addr=%h arready=%b exp 1", a, bus.s_axi_arready);
        end else begin
            gnt_log = {gnt_log, "R"};
            if (push) sb.push_back('{1'b0, r, d});
        end
        @(negedge clk);
        bus.s_axi_arvalid = 1'b0;
    endtask

    task automatic send_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] r);
        int n;
        n = 0;
        @(negedge clk);
        bus.s_axi_awaddr  = a;
        bus.s_axi_awprot  = 3'b010;
        bus.s_axi_wdata   = d;
        bus.s_axi_wstrb   = s;
        bus.s_axi_awvalid = 1'b1;
        bus.s_axi_wvalid  = 1'b1;
        #1;
        while (!bus.s_axi_awready && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (bus.s_axi_awready !== 1'b1 || bus.s_axi_wready !== 1'b1) begin
            errors++;
            $display("FAIL aw_grant addr=%h awready=%b wready=%b exp 1 1", a, bus.s_axi_awready, bus.s_axi_wready);
        end else begin
            gnt_log = {gnt_log, "W"};
            sb.push_back('{1'b1, r, 32'h0});
        end
        @(negedge clk);
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wvalid  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL sb_drain pending=%0d exp 0", sb.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.m_apb_psel, bus.m_apb_penable, bus.m_apb_pwrite, bus.s_axi_rvalid, bus.s_axi_bvalid,
             bus.s_axi_arready, bus.s_axi_awready, bus.s_axi_wready} !== 11'b0) begin
            errors++;
            $display("FAIL reset_ctrl psel=%b pen=%b pwr=%b rv=%b bv=%b ar=%b aw=%b w=%b exp all 0",
                     bus.m_apb_psel, bus.m_apb_penable, bus.m_apb_pwrite, bus.s_axi_rvalid, bus.s_axi_bvalid,
                     bus.s_axi_arready, bus.s_axi_awready, bus.s_axi_wready);
        end
        checks++;
        if ({bus.m_apb_paddr, bus.m_apb_pwdata, bus.m_apb_pstrb, bus.m_apb_pprot, bus.s_axi_rdata, bus.s_axi_rresp} !== '0) begin
            errors++;
            $display("FAIL reset_data paddr=%h pwdata=%h pstrb=%b pprot=%b rdata=%h rresp=%b exp 0",
                     bus.m_apb_paddr, bus.m_apb_pwdata, bus.m_apb_pstrb, bus.m_apb_pprot, bus.s_axi_rdata, bus.s_axi_rresp);
        end
        rst = 1'b0;
    endtask

    task automatic test_read_zero_wait();
        wait_cfg = 0;
        err_cfg  = 1'b0;
        send_rd(32'h204, 1'b1, 2'b00, 32'hCAFE_F00D);
        checks++;
        if (bus.m_apb_psel !== 4'b0100 || bus.m_apb_penable !== 1'b0 || bus.m_apb_paddr !== 32'h204 ||
            bus.m_apb_pwrite !== 1'b0 || bus.m_apb_pstrb !== 4'b0 || bus.m_apb_pprot !== 3'b001) begin
            errors++;
            $display("FAIL rd_setup psel=%b pen=%b paddr=%h pwr=%b pstrb=%b pprot=%b exp 0100 0 00000204 0 0000 001",
                     bus.m_apb_psel, bus.m_apb_penable, bus.m_apb_paddr, bus.m_apb_pwrite, bus.m_apb_pstrb, bus.m_apb_pprot);
        end
        @(negedge clk);
        checks++;
        if (bus.m_apb_psel !== 4'b0100 || bus.m_apb_penable !== 1'b1 || bus.s_axi_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rd_access psel=%b pen=%b rvalid=%b exp 0100 1 0", bus.m_apb_psel, bus.m_apb_penable, bus.s_axi_rvalid);
        end
        @(negedge clk);
        checks++;
        if (bus.s_axi_rvalid !== 1'b1 || bus.s_axi_rdata !== 32'hCAFE_F00D || bus.s_axi_rresp !== 2'b00 ||
            bus.m_apb_psel !== 4'b0 || bus.m_apb_penable !== 1'b0) begin
            errors++;
            $display("FAIL rd_t3 rvalid=%b rdata=%h rresp=%b psel=%b pen=%b exp 1 cafef00d 00 0000 0",
                     bus.s_axi_rvalid, bus.s_axi_rdata, bus.s_axi_rresp, bus.m_apb_psel, bus.m_apb_penable);
        end
        bus.s_axi_rready = 1'b1;
        @(negedge clk);
        bus.s_axi_rready = 1'b0;
        checks++;
        if (bus.s_axi_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rd_release rvalid=%b exp 0", bus.s_axi_rvalid);
        end
    endtask

    task automatic test_write_wait();
        int n;
        wait_cfg = 3;
        err_cfg  = 1'b1;
        bus.s_axi_bready = 1'b1;
        send_wr(32'h108, 32'h1234_5678, 4'b0011, 2'b10);
        checks++;
        if (bus.m_apb_psel !== 4'b0010 || bus.m_apb_pwrite !== 1'b1 || bus.m_apb_pstrb !== 4'b0011 ||
            bus.m_apb_pwdata !== 32'h1234_5678 || bus.m_apb_paddr !== 32'h108 || bus.m_apb_pprot !== 3'b010) begin
            errors++;
            $display("FAIL wr_setup psel=%b pwr=%b pstrb=%b pwdata=%h paddr=%h pprot=%b exp 0010 1 0011 12345678 00000108 010",
                     bus.m_apb_psel, bus.m_apb_pwrite, bus.m_apb_pstrb, bus.m_apb_pwdata, bus.m_apb_paddr, bus.m_apb_pprot);
        end
        n = 1;
        while (!bus.s_axi_bvalid && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 6 || bus.s_axi_bresp !== 2'b10) begin
            errors++;
            $display("FAIL wr_latency cycles=%0d bresp=%b exp 6 10", n, bus.s_axi_bresp);
        end
        drain();
        bus.s_axi_bready = 1'b0;
        err_cfg = 1'b0;
        wait_cfg = 0;
    endtask

    task automatic test_arbitration();
        do_reset();
        gnt_log = "";
        bus.s_axi_rready = 1'b1;
        bus.s_axi_bready = 1'b1;
        fork
            begin
                send_rd(32'h000, 1'b1, 2'b00, 32'h1000_0000);
                send_rd(32'h104, 1'b1, 2'b00, 32'h1000_0001);
            end
            send_wr(32'h30C, 32'hA5A5_5A5A, 4'b1111, 2'b00);
        join
        drain();
        checks++;
        if (gnt_log != "RWR") begin
            errors++;
            $display("FAIL arb_order got %s exp RWR", gnt_log);
        end
        bus.s_axi_rready = 1'b0;
        bus.s_axi_bready = 1'b0;
    endtask

    task automatic test_aw_only();
        @(negedge clk);
        bus.s_axi_awaddr  = 32'h008;
        bus.s_axi_awprot  = 3'b000;
        bus.s_axi_wdata   = 32'h0BAD_BEEF;
        bus.s_axi_wstrb   = 4'b1111;
        bus.s_axi_awvalid = 1'b1;
        bus.s_axi_bready  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (bus.s_axi_awready !== 1'b0 || bus.s_axi_wready !== 1'b0 || bus.m_apb_psel !== 4'b0) begin
                errors++;
                $display("FAIL aw_only cycle=%0d awready=%b wready=%b psel=%b exp 0 0 0000",
                         i, bus.s_axi_awready, bus.s_axi_wready, bus.m_apb_psel);
            end
            @(negedge clk);
        end
        bus.s_axi_wvalid = 1'b1;
        #1;
        checks++;
        if (bus.s_axi_awready !== 1'b1 || bus.s_axi_wready !== 1'b1) begin
            errors++;
            $display("FAIL aw_w_join awready=%b wready=%b exp 1 1", bus.s_axi_awready, bus.s_axi_wready);
        end else begin
            sb.push_back('{1'b1, 2'b00, 32'h0});
        end
        @(negedge clk);
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wvalid  = 1'b0;
        drain();
        bus.s_axi_bready = 1'b0;
    endtask

    task automatic test_decerr();
        send_rd(32'h400, 1'b1, 2'b11, 32'h0);
        checks++;
        if (bus.m_apb_psel !== 4'b0 || bus.s_axi_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL dec_t1 psel=%b rvalid=%b exp 0000 0", bus.m_apb_psel, bus.s_axi_rvalid);
        end
        @(negedge clk);
        checks++;
        if (bus.s_axi_rvalid !== 1'b1 || bus.s_axi_rresp !== 2'b11 || bus.s_axi_rdata !== 32'h0 || bus.m_apb_psel !== 4'b0) begin
            errors++;
            $display("FAIL dec_t2 rvalid=%b rresp=%b rdata=%h psel=%b exp 1 11 00000000 0000",
                     bus.s_axi_rvalid, bus.s_axi_rresp, bus.s_axi_rdata, bus.m_apb_psel);
        end
        bus.s_axi_rready = 1'b1;
        @(negedge clk);
        bus.s_axi_rready = 1'b0;
        drain();
    endtask

    task automatic test_timeout();
        int n;
        wait_cfg = 1000;
        send_rd(32'h010, 1'b1, 2'b10, 32'h0);
        n = 1;
        while (!bus.s_axi_rvalid && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== 18 || bus.s_axi_rresp !== 2'b10 || bus.m_apb_psel !== 4'b0 || bus.m_apb_penable !== 1'b0) begin
            errors++;
            $display("FAIL to_abort cycles=%0d rresp=%b psel=%b pen=%b exp 18 10 0000 0",
                     n, bus.s_axi_rresp, bus.m_apb_psel, bus.m_apb_penable);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.s_axi_rvalid !== 1'b1 || bus.s_axi_rdata !== 32'h0 || bus.s_axi_rresp !== 2'b10) begin
                errors++;
                $display("FAIL to_hold cycle=%0d rvalid=%b rdata=%h rresp=%b exp 1 00000000 10",
                         i, bus.s_axi_rvalid, bus.s_axi_rdata, bus.s_axi_rresp);
            end
        end
        bus.s_axi_rready = 1'b1;
        @(negedge clk);
        bus.s_axi_rready = 1'b0;
        drain();
    endtask

    task automatic test_reset_mid();
        wait_cfg = 1000;
        send_rd(32'h300, 1'b0, 2'b00, 32'h0);
        @(negedge clk);
        checks++;
        if (bus.m_apb_psel !== 4'b1000 || bus.m_apb_penable !== 1'b1) begin
            errors++;
            $display("FAIL rm_access psel=%b pen=%b exp 1000 1", bus.m_apb_psel, bus.m_apb_penable);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (bus.m_apb_psel !== 4'b0 || bus.m_apb_penable !== 1'b0 || bus.s_axi_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rm_drop psel=%b pen=%b rvalid=%b exp 0000 0 0", bus.m_apb_psel, bus.m_apb_penable, bus.s_axi_rvalid);
        end
        bus.s_axi_rready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.s_axi_rvalid !== 1'b0 || bus.m_apb_psel !== 4'b0) begin
                errors++;
                $display("FAIL rm_quiet cycle=%0d rvalid=%b psel=%b exp 0 0000", i, bus.s_axi_rvalid, bus.m_apb_psel);
            end
        end
        bus.s_axi_rready = 1'b0;
        wait_cfg = 0;
        drain();
    endtask

    initial begin
        bus.s_axi_awaddr  = '0;
        bus.s_axi_araddr  = '0;
        bus.s_axi_awprot  = '0;
        bus.s_axi_arprot  = '0;
        bus.s_axi_awvalid = 1'b0;
        bus.s_axi_arvalid = 1'b0;
        bus.s_axi_wdata   = '0;
        bus.s_axi_wstrb   = '0;
        bus.s_axi_wvalid  = 1'b0;
        bus.s_axi_bready  = 1'b0;
        bus.s_axi_rready  = 1'b0;
        test_reset();
        test_read_zero_wait();
        test_write_wait();
        test_arbitration();
        test_aw_only();
        test_decerr();
        test_timeout();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
